// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard for the 5-stage MIPS pipeline: stall, flush, freeze and forward selects.
// Optional macro STORE_FWD_EN: forward load data straight to a dependent store instead of stalling.
module hazard_scoreboard #(
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned MD_LAT   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       issue_valid,
   input  logic [4:0] addr_rs,
   input  logic [4:0] addr_rt,
   input  logic       rs_used,
   input  logic       rt_used,
   input  logic       is_store,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [1:0] wr_class,
   input  logic       br_taken,
   output logic       en_f,
   output logic       en_d,
   output logic       en_e,
   output logic       en_m,
   output logic       rst_d,
   output logic       rst_e,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b,
   output logic       fwd_m,
   output logic       md_busy,
   output logic       mem_wait
);

   typedef enum logic [1:0] {
      CLS_ALU    = 2'd0,
      CLS_LOAD   = 2'd1,
      CLS_MULDIV = 2'd2,
      CLS_RSVD   = 2'd3
   } cls_e;

   typedef struct packed {
      logic       wen;
      logic [4:0] addr;
      cls_e       cls;
   } stage_t;

   stage_t     e_q, m_q;
   logic [1:0] mem_cnt;
   logic [3:0] md_cnt;
   logic [4:0] md_dst;

   cls_e dec_cls;
   logic e_hit_a, e_hit_b, m_hit_a, m_hit_b;
   logic lu_a, lu_b, md_hit, st_fwd, stall;

   assign md_busy  = (md_cnt != 4'd0);
   assign mem_wait = (m_q.cls == CLS_LOAD) && m_q.wen && (mem_cnt != 2'd0);

   // Source matching against the shadow E/M copies; $0 never matches
   always_comb begin
      dec_cls = (wr_class == 2'd3) ? CLS_ALU : cls_e'(wr_class);
      e_hit_a = issue_valid && rs_used && (addr_rs != 5'd0) && e_q.wen && (e_q.addr == addr_rs);
      e_hit_b = issue_valid && rt_used && (addr_rt != 5'd0) && e_q.wen && (e_q.addr == addr_rt);
      m_hit_a = issue_valid && rs_used && (addr_rs != 5'd0) && m_q.wen && (m_q.addr == addr_rs);
      m_hit_b = issue_valid && rt_used && (addr_rt != 5'd0) && m_q.wen && (m_q.addr == addr_rt);
`ifdef STORE_FWD_EN
      st_fwd  = e_hit_b && (e_q.cls == CLS_LOAD) && is_store;
`else
      st_fwd  = 1'b0;
`endif
      lu_a    = e_hit_a && (e_q.cls == CLS_LOAD);
      lu_b    = e_hit_b && (e_q.cls == CLS_LOAD) && !st_fwd;
      md_hit  = issue_valid && md_busy &&
                ((rs_used && (addr_rs != 5'd0) && (addr_rs == md_dst)) ||
                 (rt_used && (addr_rt != 5'd0) && (addr_rt == md_dst)) ||
                 (dec_cls == CLS_MULDIV));
      stall   = lu_a || lu_b || md_hit;
   end

   // Pipeline control and forward selects
   always_comb begin
      en_f  = !mem_wait && !stall;
      en_d  = !mem_wait && !stall;
      en_e  = !mem_wait;
      en_m  = !mem_wait;
      rst_e = stall && !mem_wait;
      rst_d = br_taken && !stall && !mem_wait;
      fwd_m = st_fwd;
      fwd_a = 2'd0;
      if (e_hit_a)      fwd_a = (e_q.cls == CLS_LOAD) ? 2'd0 : 2'd1;
      else if (m_hit_a) fwd_a = (m_q.cls == CLS_LOAD) ? 2'd3 : 2'd2;
      fwd_b = 2'd0;
      if (e_hit_b)      fwd_b = (e_q.cls == CLS_LOAD) ? 2'd0 : 2'd1;
      else if (m_hit_b) fwd_b = (m_q.cls == CLS_LOAD) ? 2'd3 : 2'd2;
   end

`ifndef STORE_FWD_EN
   logic unused_is_store;
   assign unused_is_store = is_store;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q     <= '0;
         m_q     <= '0;
         mem_cnt <= 2'd0;
         md_cnt  <= 4'd0;
         md_dst  <= 5'd0;
      end else begin
         // M advances unless frozen; a frozen load counts down its remaining latency
         if (!mem_wait) begin
            m_q     <= e_q;
            mem_cnt <= (e_q.cls == CLS_LOAD) ? 2'(LOAD_LAT - 1) : 2'd0;
         end else begin
            mem_cnt <= mem_cnt - 2'd1;
         end
         if (!mem_wait) begin
            if (!stall) begin
               e_q.wen  <= issue_valid && wr_en && (wr_addr != 5'd0) && (dec_cls != CLS_MULDIV);
               e_q.addr <= wr_addr;
               e_q.cls  <= dec_cls;
            end else begin
               e_q.wen  <= 1'b0;
            end
         end
         // MUL/DIV result tracked here only; it lands in the RF when the timer expires
         if (!mem_wait && !stall && issue_valid && (dec_cls == CLS_MULDIV)) begin
            md_cnt <= 4'(MD_LAT);
            md_dst <= wr_addr;
         end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one instance with LOAD_LAT=1, one with LOAD_LAT=3, shared stimulus.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       issue_valid, rs_used, rt_used, is_store, wr_en, br_taken;
   logic [4:0] addr_rs, addr_rt, wr_addr;
   logic [1:0] wr_class;

   logic       en_f, en_d, en_e, en_m, rst_d, rst_e, fwd_m, md_busy, mem_wait;
   logic [1:0] fwd_a, fwd_b;
   logic       en_f3, en_d3, en_e3, en_m3, rst_d3, rst_e3, fwd_m3, md_busy3, mem_wait3;
   logic [1:0] fwd_a3, fwd_b3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.LOAD_LAT(1), .MD_LAT(4)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .addr_rs(addr_rs), .addr_rt(addr_rt),
      .rs_used(rs_used), .rt_used(rt_used), .is_store(is_store), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_class(wr_class), .br_taken(br_taken), .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m),
      .rst_d(rst_d), .rst_e(rst_e), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_m(fwd_m),
      .md_busy(md_busy), .mem_wait(mem_wait));

   hazard_scoreboard #(.LOAD_LAT(3), .MD_LAT(4)) dut3 (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .addr_rs(addr_rs), .addr_rt(addr_rt),
      .rs_used(rs_used), .rt_used(rt_used), .is_store(is_store), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_class(wr_class), .br_taken(br_taken), .en_f(en_f3), .en_d(en_d3), .en_e(en_e3), .en_m(en_m3),
      .rst_d(rst_d3), .rst_e(rst_e3), .fwd_a(fwd_a3), .fwd_b(fwd_b3), .fwd_m(fwd_m3),
      .md_busy(md_busy3), .mem_wait(mem_wait3));

   task automatic set_dec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic rsu, input logic rtu, input logic st, input logic we,
                          input logic [4:0] wa, input logic [1:0] cls, input logic br);
      issue_valid = v;  addr_rs = rs;  addr_rt = rt;  rs_used = rsu;  rt_used = rtu;
      is_store = st;    wr_en = we;    wr_addr = wa;  wr_class = cls; br_taken = br;
   endtask

   task automatic nop();
      set_dec(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      nop();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #2;
      total++; if (en_f !== 1'b1)     begin bad++; $display("FAIL reset_en_f got=%0b exp=1", en_f); end
      total++; if (en_d !== 1'b1)     begin bad++; $display("FAIL reset_en_d got=%0b exp=1", en_d); end
      total++; if (en_e !== 1'b1)     begin bad++; $display("FAIL reset_en_e got=%0b exp=1", en_e); end
      total++; if (en_m !== 1'b1)     begin bad++; $display("FAIL reset_en_m got=%0b exp=1", en_m); end
      total++; if (rst_d !== 1'b0)    begin bad++; $display("FAIL reset_rst_d got=%0b exp=0", rst_d); end
      total++; if (rst_e !== 1'b0)    begin bad++; $display("FAIL reset_rst_e got=%0b exp=0", rst_e); end
      total++; if (fwd_a !== 2'd0)    begin bad++; $display("FAIL reset_fwd_a got=%0d exp=0", fwd_a); end
      total++; if (fwd_b !== 2'd0)    begin bad++; $display("FAIL reset_fwd_b got=%0d exp=0", fwd_b); end
      total++; if (fwd_m !== 1'b0)    begin bad++; $display("FAIL reset_fwd_m got=%0b exp=0", fwd_m); end
      total++; if (md_busy !== 1'b0)  begin bad++; $display("FAIL reset_md_busy got=%0b exp=0", md_busy); end
      total++; if (mem_wait !== 1'b0) begin bad++; $display("FAIL reset_mem_wait got=%0b exp=0", mem_wait); end
   endtask

   // add $t0 ; add $t1,$t0,$t0 ; add reading $t0 from M ; writes/reads of $0
   task automatic test_alu_fwd();
      do_reset();
      set_dec(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 2'd0, 1'b0);
      tick();
      set_dec(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 2'd0, 1'b0);
      #2;
      total++; if (fwd_a !== 2'd1) begin bad++; $display("FAIL alu_e_fwd_a got=%0d exp=1", fwd_a); end
      total++; if (fwd_b !== 2'd1) begin bad++; $display("FAIL alu_e_fwd_b got=%0d exp=1", fwd_b); end
      total++; if (en_f !== 1'b1 || rst_e !== 1'b0)
         begin bad++; $display("FAIL alu_e_nostall got en_f=%0b rst_e=%0b exp en_f=1 rst_e=0", en_f, rst_e); end
      tick();
      set_dec(1'b1, 5'd11, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 2'd3, 1'b0);
      #2;
      total++; if (fwd_b !== 2'd2) begin bad++; $display("FAIL alu_m_fwd_b got=%0d exp=2", fwd_b); end
      total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL alu_nomatch_fwd_a got=%0d exp=0", fwd_a); end
      do_reset();
      set_dec(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 2'd1, 1'b0);
      tick();
      set_dec(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 2'd0, 1'b0);
      #2;
      total++; if (fwd_a !== 2'd0 || en_f !== 1'b1)
         begin bad++; $display("FAIL zero_reg got fwd_a=%0d en_f=%0b exp fwd_a=0 en_f=1", fwd_a, en_f); end
   endtask

   // lw $t0 ; add $t1,$t0,$0 with LOAD_LAT=1
   task automatic test_load_use();
      do_reset();
      set_dec(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 2'd1, 1'b0);
      tick();
      set_dec(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 2'd0, 1'b0);
      #2;
      total++; if (en_f !== 1'b0 || en_d !== 1'b0 || rst_e !== 1'b1 || en_e !== 1'b1)
         begin bad++; $display("FAIL lu_stall got en_f=%0b en_d=%0b rst_e=%0b en_e=%0b exp 0 0 1 1", en_f, en_d, rst_e, en_e); end
      tick();
      #2;
      total++; if (fwd_a !== 2'd3) begin bad++; $display("FAIL lu_fwd_a got=%0d exp=3", fwd_a); end
      total++; if (en_f !== 1'b1 || rst_e !== 1'b0 || mem_wait !== 1'b0)
         begin bad++; $display("FAIL lu_release got en_f=%0b rst_e=%0b mem_wait=%0b exp 1 0 0", en_f, rst_e, mem_wait); end
   endtask

   // LOAD_LAT=3 instance: load in M freezes the pipe for exactly 2 cycles
   task automatic test_mem_wait();
      do_reset();
      set_dec(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 2'd1, 1'b0);
      tick();
      nop();
      #2;
      total++; if (mem_wait3 !== 1'b0) begin bad++; $display("FAIL mw_load_in_e got=%0b exp=0", mem_wait3); end
      tick();
      set_dec(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 2'd0, 1'b0);
      #2;
      total++; if (mem_wait3 !== 1'b1 || en_m3 !== 1'b0 || en_e3 !== 1'b0 || en_f3 !== 1'b0 || en_d3 !== 1'b0)
         begin bad++; $display("FAIL mw_cycle1 got mw=%0b en_m=%0b en_e=%0b en_f=%0b en_d=%0b exp 1 0 0 0 0",
                               mem_wait3, en_m3, en_e3, en_f3, en_d3); end
      total++; if (mem_wait !== 1'b0) begin bad++; $display("FAIL mw_lat1_nowait got=%0b exp=0", mem_wait); end
      tick();
      #2;
      total++; if (mem_wait3 !== 1'b1 || en_m3 !== 1'b0)
         begin bad++; $display("FAIL mw_cycle2 got mw=%0b en_m=%0b exp 1 0", mem_wait3, en_m3); end
      tick();
      #2;
      total++; if (mem_wait3 !== 1'b0 || en_m3 !== 1'b1 || en_f3 !== 1'b1)
         begin bad++; $display("FAIL mw_resume got mw=%0b en_m=%0b en_f=%0b exp 0 1 1", mem_wait3, en_m3, en_f3); end
      total++; if (fwd_a3 !== 2'd3) begin bad++; $display("FAIL mw_fwd_a got=%0d exp=3", fwd_a3); end
   endtask

   // mult $t2 ; add reading $t2 -> 4 stall cycles; back-to-back MULDIV also stalls
   task automatic test_muldiv();
      do_reset();
      set_dec(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 2'd2, 1'b0);
      tick();
      set_dec(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 2'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #2;
         total++; if (en_f !== 1'b0 || rst_e !== 1'b1 || md_busy !== 1'b1)
            begin bad++; $display("FAIL md_stall%0d got en_f=%0b rst_e=%0b md_busy=%0b exp 0 1 1", i, en_f, rst_e, md_busy); end
         tick();
      end
      #2;
      total++; if (en_f !== 1'b1 || rst_e !== 1'b0 || fwd_a !== 2'd0 || md_busy !== 1'b0)
         begin bad++; $display("FAIL md_release got en_f=%0b rst_e=%0b fwd_a=%0d md_busy=%0b exp 1 0 0 0",
                               en_f, rst_e, fwd_a, md_busy); end
      do_reset();
      set_dec(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 2'd2, 1'b0);
      tick();
      set_dec(1'b1, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 5'd14, 2'd2, 1'b0);
      #2;
      total++; if (en_f !== 1'b0 || rst_e !== 1'b1)
         begin bad++; $display("FAIL md_b2b got en_f=%0b rst_e=%0b exp 0 1", en_f, rst_e); end
   endtask

   // lw $t0 ; sw $t0,0($sp)
   task automatic test_store_fwd();
      do_reset();
      set_dec(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 2'd1, 1'b0);
      tick();
      set_dec(1'b1, 5'd29, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
      #2;
`ifdef STORE_FWD_EN
      total++; if (fwd_m !== 1'b1 || en_f !== 1'b1 || rst_e !== 1'b0)
         begin bad++; $display("FAIL sf_fwd got fwd_m=%0b en_f=%0b rst_e=%0b exp 1 1 0", fwd_m, en_f, rst_e); end
`else
      total++; if (fwd_m !== 1'b0 || en_f !== 1'b0 || rst_e !== 1'b1)
         begin bad++; $display("FAIL sf_stall got fwd_m=%0b en_f=%0b rst_e=%0b exp 0 0 1", fwd_m, en_f, rst_e); end
      tick();
      #2;
      total++; if (fwd_b !== 2'd3 || en_f !== 1'b1)
         begin bad++; $display("FAIL sf_fwd_b got fwd_b=%0d en_f=%0b exp 3 1", fwd_b, en_f); end
`endif
   endtask

   task automatic test_branch();
      do_reset();
      set_dec(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1);
      #2;
      total++; if (rst_d !== 1'b1 || en_f !== 1'b1)
         begin bad++; $display("FAIL br_flush got rst_d=%0b en_f=%0b exp 1 1", rst_d, en_f); end
      tick();
      set_dec(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 2'd1, 1'b0);
      tick();
      set_dec(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1);
      #2;
      total++; if (rst_d !== 1'b0 || rst_e !== 1'b1)
         begin bad++; $display("FAIL br_suppressed got rst_d=%0b rst_e=%0b exp 0 1", rst_d, rst_e); end
   endtask

   // Async reset with MUL/DIV timer at 3 and a load frozen in M
   task automatic test_async_reset();
      do_reset();
      set_dec(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 2'd1, 1'b0);
      tick();
      set_dec(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 2'd2, 1'b0);
      tick();
      nop();
      tick();
      #2;
      total++; if (md_busy !== 1'b1 || mem_wait3 !== 1'b1)
         begin bad++; $display("FAIL ar_pre got md_busy=%0b mem_wait3=%0b exp 1 1", md_busy, mem_wait3); end
      rst = 1'b1;
      #1;
      total++; if (md_busy !== 1'b0 || md_busy3 !== 1'b0 || mem_wait3 !== 1'b0)
         begin bad++; $display("FAIL ar_clear got md_busy=%0b md_busy3=%0b mem_wait3=%0b exp 0 0 0", md_busy, md_busy3, mem_wait3); end
      total++; if (en_f !== 1'b1 || en_d !== 1'b1 || en_e !== 1'b1 || en_m !== 1'b1 || en_m3 !== 1'b1)
         begin bad++; $display("FAIL ar_en got en_f=%0b en_d=%0b en_e=%0b en_m=%0b en_m3=%0b exp all 1",
                               en_f, en_d, en_e, en_m, en_m3); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      nop();
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_mem_wait();
      test_muldiv();
      test_store_fwd();
      test_branch();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
